// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types and helpers for the T-flip-flop up/down counter.
//   - count_dir_e : direction encoding of the 'up' input
//   - MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   - clamp_load  : limits a parallel-load value to the top of the count range
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Values at or above MODULUS land on MODULUS-1 (max_val).
    // 33 bits covers WIDTH up to 32 with one bit of headroom.
    function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                               input logic [32:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// tff_cell
//   One T flip-flop: q toggles on a rising clk edge when t is high.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset, clears q to 0
//     t     - toggle enable
//     q     - stored bit
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter
//   Modulo-MODULUS up/down counter whose state is a row of T flip-flops.
//   Shared combinational logic computes the next count; each cell toggles
//   where the next count differs from the current one.
//   Parameters:
//     WIDTH    - counter width (2..32)
//     MODULUS  - count range 0..MODULUS-1 (2..2**WIDTH)
//     SATURATE - MODE_WRAP: wrap at range ends, MODE_SAT: hold at range ends
//   Ports:
//     clk      - rising-edge clock
//     rst_n    - asynchronous active-low reset
//     clr      - synchronous clear (highest priority)
//     load     - synchronous parallel load of load_val (clamped to range)
//     load_val - value to load
//     en       - count enable
//     up       - 1 = increment, 0 = decrement
//     count    - current count (registered)
//     tc       - count is at the range end in the current direction
//     wrap     - one-cycle pulse after a wrapping edge
//     sat      - level, counter is held at a range end (MODE_SAT only)
module tff_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // One spare bit so MODULUS-1 and +1 never overflow when MODULUS = 2**WIDTH.
    localparam logic [WIDTH:0] MAX_VAL  = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0] ONE      = (WIDTH+1)'(1);
    localparam bit             SAT_MODE = (SATURATE == MODE_SAT);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("tff_updown_counter: WIDTH must be in 2..32");
    end

    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("tff_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    count_dir_e       dir;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   nxt_ext;
    logic [WIDTH-1:0] nxt_count;
    logic [WIDTH-1:0] toggle;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign dir      = count_dir_e'(up);
    assign cnt_ext  = {1'b0, count};
    assign load_ext = (WIDTH+1)'(clamp_load(33'(load_val), 33'(MAX_VAL)));

    always_comb begin
        nxt_ext  = cnt_ext;
        wrap_nxt = 1'b0;
        sat_nxt  = sat;
        if (clr) begin
            nxt_ext = '0;
            sat_nxt = 1'b0;
        end else if (load) begin
            nxt_ext = load_ext;
            sat_nxt = 1'b0;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (cnt_ext == MAX_VAL) begin
                    if (SAT_MODE) begin
                        sat_nxt = 1'b1;
                    end else begin
                        nxt_ext  = '0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    nxt_ext = cnt_ext + ONE;
                    sat_nxt = 1'b0;
                end
            end else begin
                if (cnt_ext == '0) begin
                    if (SAT_MODE) begin
                        sat_nxt = 1'b1;
                    end else begin
                        nxt_ext  = MAX_VAL;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    nxt_ext = cnt_ext - ONE;
                    sat_nxt = 1'b0;
                end
            end
        end
        if (!SAT_MODE) begin
            sat_nxt = 1'b0;
        end
    end

    // nxt_ext never exceeds MAX_VAL, so its top bit is always zero.
    assign nxt_count = WIDTH'(nxt_ext);
    assign toggle    = count ^ nxt_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_tff (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (toggle[i]),
            .q     (count[i])
        );
    end

    assign tc = (dir == DIR_UP) ? (cnt_ext == MAX_VAL) : (cnt_ext == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter
//   Drives six counter configurations from one shared stimulus stream and
//   compares each against an arithmetic reference model every cycle.
module tb_tff_updown_counter;

    localparam int NI = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0]    c0, c1, c2, c3, c5;
    logic [3:0]    c4;
    logic [NI-1:0] tc_v, wrap_v, sat_v;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // configuration of each instance, index order matches u0..u5
    int unsigned mods [NI] = '{256, 10, 10, 100, 16, 100};
    bit          satms[NI] = '{0, 0, 1, 0, 0, 1};
    int unsigned wids [NI] = '{8, 8, 8, 8, 4, 8};

    longint unsigned m_cnt [NI];
    bit              m_wrap[NI];
    bit              m_sat [NI];

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(8), .MODULUS(64'd256), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(c0), .tc(tc_v[0]), .wrap(wrap_v[0]), .sat(sat_v[0]));
    tff_updown_counter #(.WIDTH(8), .MODULUS(64'd10), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(c1), .tc(tc_v[1]), .wrap(wrap_v[1]), .sat(sat_v[1]));
    tff_updown_counter #(.WIDTH(8), .MODULUS(64'd10), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(c2), .tc(tc_v[2]), .wrap(wrap_v[2]), .sat(sat_v[2]));
    tff_updown_counter #(.WIDTH(8), .MODULUS(64'd100), .SATURATE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(c3), .tc(tc_v[3]), .wrap(wrap_v[3]), .sat(sat_v[3]));
    tff_updown_counter #(.WIDTH(4), .MODULUS(64'd16), .SATURATE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .up(up), .count(c4), .tc(tc_v[4]), .wrap(wrap_v[4]), .sat(sat_v[4]));
    tff_updown_counter #(.WIDTH(8), .MODULUS(64'd100), .SATURATE(1)) u5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(c5), .tc(tc_v[5]), .wrap(wrap_v[5]), .sat(sat_v[5]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
            m_sat[i]  = 1'b0;
        end
    endtask

    // One clock edge of the reference: modular arithmetic for wrap mode,
    // min/max clipping for saturate mode.
    task automatic model_edge();
        longint unsigned m, lv, prev;
        for (int i = 0; i < NI; i++) begin
            m    = mods[i];
            lv   = longint'(load_val) % (64'd1 << wids[i]);
            prev = m_cnt[i];
            m_wrap[i] = 1'b0;
            if (clr) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (lv >= m) ? m - 1 : lv;
                m_sat[i] = 1'b0;
            end else if (en) begin
                if (satms[i]) begin
                    if (up) m_cnt[i] = (prev + 1 > m - 1) ? m - 1 : prev + 1;
                    else    m_cnt[i] = (prev == 0) ? 0 : prev - 1;
                    m_sat[i] = (m_cnt[i] == prev);
                end else begin
                    if (up) m_cnt[i] = (prev + 1) % m;
                    else    m_cnt[i] = (prev + m - 1) % m;
                    m_wrap[i] = up ? (m_cnt[i] < prev) : (m_cnt[i] > prev);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] obs[NI];
        logic       exp_tc;
        obs = '{c0, c1, c2, c3, {4'h0, c4}, c5};
        for (int i = 0; i < NI; i++) begin
            exp_tc = up ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
            chk($sformatf("u%0d.count", i), 64'(obs[i]), m_cnt[i]);
            chk($sformatf("u%0d.wrap", i), 64'(wrap_v[i]), 64'(m_wrap[i]));
            chk($sformatf("u%0d.sat", i), 64'(sat_v[i]), 64'(m_sat[i]));
            chk($sformatf("u%0d.tc", i), 64'(tc_v[i]), 64'(exp_tc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        // reset held for three cycles, down direction so tc reads 1
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_count", 64'(c0), 64'd0);
        chk("rst_wrap", 64'(wrap_v[0]), 64'd0);

        up = 1'b1;
        en = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 9) begin
                chk("mod10_9", 64'(c1), 64'd9);
                chk("mod10_tc", 64'(tc_v[1]), 64'd1);
            end
            if (k == 10) begin
                chk("ten_up", 64'(c0), 64'h0A);
                chk("mod10_wrap_cnt", 64'(c1), 64'd0);
                chk("mod10_wrap_pulse", 64'(wrap_v[1]), 64'd1);
            end
            if (k == 11) chk("mod10_wrap_drop", 64'(wrap_v[1]), 64'd0);
            if (k == 16) begin
                chk("w4_full_cnt", 64'(c4), 64'd0);
                chk("w4_full_wrap", 64'(wrap_v[4]), 64'd1);
                chk("w4_no_x", 64'($isunknown(c4)), 64'd0);
            end
        end

        clr = 1'b1;
        step();
        clr = 1'b0;
        up  = 1'b0;
        step();
        chk("down_wrap_cnt", 64'(c1), 64'd9);
        chk("down_wrap_pulse", 64'(wrap_v[1]), 64'd1);
        chk("down_sat_cnt", 64'(c2), 64'd0);
        chk("down_sat_flag", 64'(sat_v[2]), 64'd1);
        chk("down_sat_nowrap", 64'(wrap_v[2]), 64'd0);

        load = 1'b1;
        load_val = 8'h37;
        step();
        chk("load_37", 64'(c0), 64'h37);
        load_val = 8'hFF;
        step();
        chk("load_clamp", 64'(c3), 64'd99);
        clr = 1'b1;
        step();
        chk("clr_over_load", 64'(c0), 64'd0);
        clr = 1'b0;

        load_val = 8'h55;
        step();
        load = 1'b0;
        up = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst", 64'(c0), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("resume", 64'(c0), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) == 1;
            load_val = 8'($urandom);
            step();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
